// File: rtl/iecdrv_pkg.sv
// Shared types and MSB-first sub-byte field helpers for the IEC drive track buffer.
package iecdrv_pkg;

    typedef enum logic [1:0] {IDLE, SREAD, SMERGE, BACC} state_t;

    function automatic bit narrow_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8);
    endfunction

    // Bit offset 0 is the byte MSB, matching the order bits come off the disk.
    function automatic logic [7:0] field_mask(input int n, input logic [2:0] o);
        logic [7:0] m;
        m = 8'((9'd1 << n) - 9'd1);
        m = m << (8 - n - int'(o));
        return m;
    endfunction

    function automatic logic [7:0] field_get(input logic [7:0] b, input int n, input logic [2:0] o);
        return (b & field_mask(n, o)) >> (8 - n - int'(o));
    endfunction

    function automatic logic [7:0] field_put(input logic [7:0] b, input logic [7:0] d,
                                             input int n, input logic [2:0] o);
        logic [7:0] m;
        m = field_mask(n, o);
        return (b & ~m) | ((d << (8 - n - int'(o))) & m);
    endfunction

endpackage

// File: rtl/iecdrv_spram.sv
// Single-port synchronous byte RAM, read-first, one-cycle registered read.
module iecdrv_spram #(
    parameter int ADDRWIDTH = 13
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [7:0]           din,
    output logic [7:0]           dout
);

    logic [7:0] mem [0:(1 << ADDRWIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/iecdrv_bitstream_mem.sv
// Track buffer: wrap-around NARROW-bit stream path and byte path sharing one RAM port.
// Optional dirty flag enabled by defining IECDRV_BITSTREAM_DIRTY_EN.
module iecdrv_bitstream_mem
    import iecdrv_pkg::*;
#(
    parameter int ADDRWIDTH = 13,
    parameter int NARROW    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   b_req,
    input  logic                   b_we,
    input  logic [ADDRWIDTH-1:0]   b_addr,
    input  logic [7:0]             b_din,
    output logic [7:0]             b_dout,
    output logic                   b_ack,
    input  logic [ADDRWIDTH-1:0]   s_len,
    input  logic                   s_seek,
    input  logic [ADDRWIDTH+2:0]   s_seek_pos,
    input  logic                   s_advance,
    input  logic                   s_we,
    input  logic [NARROW-1:0]      s_din,
    output logic                   s_ready,
    output logic [NARROW-1:0]      s_dout,
    output logic                   s_valid,
    output logic [ADDRWIDTH+2:0]   s_pos
`ifdef IECDRV_BITSTREAM_DIRTY_EN
    ,
    output logic                   dirty,
    input  logic                   dirty_clr
`endif
);

    localparam int PW = ADDRWIDTH + 3;
    localparam logic [PW-1:0] ALIGN_MASK = ~PW'(NARROW - 1);

    if (!narrow_legal(NARROW)) begin : g_bad_narrow
        $error("NARROW must be 1, 2, 4 or 8");
    end

    state_t state_reg, state_next;
    logic step_go, byte_go;
    logic ram_we;
    logic [ADDRWIDTH-1:0] ram_addr;
    logic [7:0] ram_din, ram_dout;

    logic [ADDRWIDTH-1:0] op_addr_reg;
    logic [2:0]           op_off_reg;
    logic                 op_we_reg;
    logic [NARROW-1:0]    op_sdin_reg;
    logic [7:0]           op_bdin_reg;

    logic [PW:0]   bit_limit, pos_sum;
    logic [PW-1:0] pos_next;

    iecdrv_spram #(.ADDRWIDTH(ADDRWIDTH)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    assign s_ready = (state_reg == IDLE);

    // A zero length stands for the full buffer; an out-of-range pointer also lands on 0.
    always_comb begin
        bit_limit = (s_len == '0) ? {1'b1, {PW{1'b0}}} : {1'b0, s_len, 3'b000};
        pos_sum   = {1'b0, s_pos} + (PW+1)'(NARROW);
        pos_next  = (pos_sum >= bit_limit) ? '0 : pos_sum[PW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_go    = 1'b0;
        byte_go    = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = op_addr_reg;
        ram_din    = b_din;
        case (state_reg)
            IDLE: begin
                // Stream steps have a real-time deadline, so they win over byte requests.
                if (s_advance) begin
                    step_go    = 1'b1;
                    ram_addr   = s_pos[PW-1:3];
                    state_next = SREAD;
                end else if (b_req) begin
                    byte_go    = 1'b1;
                    ram_addr   = b_addr;
                    ram_we     = b_we;
                    state_next = BACC;
                end
            end
            SREAD:   state_next = op_we_reg ? SMERGE : IDLE;
            SMERGE: begin
                ram_we     = 1'b1;
                ram_din    = field_put(ram_dout, 8'(op_sdin_reg), NARROW, op_off_reg);
                state_next = IDLE;
            end
            BACC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_addr_reg <= '0;
            op_off_reg  <= '0;
            op_we_reg   <= 1'b0;
            op_sdin_reg <= '0;
            op_bdin_reg <= '0;
            s_pos       <= '0;
            s_dout      <= '0;
            s_valid     <= 1'b0;
            b_dout      <= '0;
            b_ack       <= 1'b0;
        end else begin
            s_valid <= 1'b0;
            b_ack   <= 1'b0;
            if (step_go) begin
                op_addr_reg <= s_pos[PW-1:3];
                op_off_reg  <= s_pos[2:0];
                op_we_reg   <= s_we;
                op_sdin_reg <= s_din;
            end
            if (byte_go) begin
                op_addr_reg <= b_addr;
                op_we_reg   <= b_we;
                op_bdin_reg <= b_din;
            end
            if (s_seek) begin
                s_pos <= s_seek_pos & ALIGN_MASK;
            end else if (step_go) begin
                s_pos <= pos_next;
            end
            if (state_reg == SREAD && !op_we_reg) begin
                s_dout  <= NARROW'(field_get(ram_dout, NARROW, op_off_reg));
                s_valid <= 1'b1;
            end
            if (state_reg == BACC) begin
                b_dout <= op_we_reg ? op_bdin_reg : ram_dout;
                b_ack  <= 1'b1;
            end
        end
    end

`ifdef IECDRV_BITSTREAM_DIRTY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty <= 1'b0;
        end else if ((byte_go && b_we) || state_reg == SMERGE) begin
            dirty <= 1'b1;
        end else if (dirty_clr) begin
            dirty <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_iecdrv_bitstream_mem.sv
// Bench for iecdrv_bitstream_mem: NARROW=1 and NARROW=2 instances driven in lockstep.
module tb_iecdrv_bitstream_mem;

    localparam int AW = 6;

    logic clk = 1'b0;
    logic reset;
    logic b_req, b_we;
    logic [AW-1:0] b_addr;
    logic [7:0] b_din;
    logic [AW-1:0] s_len;
    logic s_seek;
    logic [AW+2:0] s_seek_pos;
    logic s_advance, s_we;
    logic [1:0] s_din;

    logic [7:0] b_dout1, b_dout2;
    logic b_ack1, b_ack2, s_ready1, s_ready2, s_valid1, s_valid2;
    logic [0:0] s_dout1;
    logic [1:0] s_dout2;
    logic [AW+2:0] s_pos1, s_pos2;
`ifdef IECDRV_BITSTREAM_DIRTY_EN
    logic dirty1, dirty2, dirty_clr;
`endif

    iecdrv_bitstream_mem #(.ADDRWIDTH(AW), .NARROW(1)) u_dut1 (
        .clk(clk), .reset(reset), .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout1), .b_ack(b_ack1), .s_len(s_len), .s_seek(s_seek), .s_seek_pos(s_seek_pos),
        .s_advance(s_advance), .s_we(s_we), .s_din(s_din[0:0]), .s_ready(s_ready1),
        .s_dout(s_dout1), .s_valid(s_valid1), .s_pos(s_pos1)
`ifdef IECDRV_BITSTREAM_DIRTY_EN
        , .dirty(dirty1), .dirty_clr(dirty_clr)
`endif
    );

    iecdrv_bitstream_mem #(.ADDRWIDTH(AW), .NARROW(2)) u_dut2 (
        .clk(clk), .reset(reset), .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout2), .b_ack(b_ack2), .s_len(s_len), .s_seek(s_seek), .s_seek_pos(s_seek_pos),
        .s_advance(s_advance), .s_we(s_we), .s_din(s_din), .s_ready(s_ready2),
        .s_dout(s_dout2), .s_valid(s_valid2), .s_pos(s_pos2)
`ifdef IECDRV_BITSTREAM_DIRTY_EN
        , .dirty(dirty2), .dirty_clr(dirty_clr)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the buffer as a flat bit array, bit k = byte k/8, MSB first.
    bit [7:0] mem_m [2][64];
    int pos_m [2];
    int len_m;

    typedef struct {
        bit [1:0] exp1;
        bit [1:0] exp2;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lim_bits();
        return ((len_m == 0) ? 64 : len_m) * 8;
    endfunction

    function automatic int mstep(input int k, input bit we, input bit [1:0] din);
        int n, p, v;
        n = k + 1;
        p = pos_m[k];
        v = 0;
        for (int i = 0; i < n; i++) begin
            int b;
            b = p + i;
            if (we) mem_m[k][b / 8][7 - (b % 8)] = din[n - 1 - i];
            else    v = v * 2 + int'(mem_m[k][b / 8][7 - (b % 8)]);
        end
        pos_m[k] = (p + n >= lim_bits()) ? 0 : p + n;
        return v;
    endfunction

    function automatic void mseek(input int v);
        pos_m[0] = v;
        pos_m[1] = v & ~1;
    endfunction

    task automatic step(input bit we, input bit [1:0] din, output int e1, output int e2);
        s_advance = 1'b1; s_we = we; s_din = din;
        @(posedge clk); #1;
        s_advance = 1'b0;
        e1 = mstep(0, we, din);
        e2 = mstep(1, we, din);
        chk("s_pos1_after_step", 32'(s_pos1), pos_m[0]);
        chk("s_pos2_after_step", 32'(s_pos2), pos_m[1]);
        chk("s_ready_busy", 32'(s_ready1), 0);
        @(posedge clk); #1;
        if (!we) begin
            chk("s_valid1", 32'(s_valid1), 1);
            chk("s_dout1", 32'(s_dout1), e1);
            chk("s_dout2", 32'(s_dout2), e2);
            chk("s_ready_read_done", 32'(s_ready2), 1);
        end else begin
            chk("s_valid_on_write", 32'(s_valid1 | s_valid2), 0);
            @(posedge clk); #1;
            chk("s_ready_write_done", 32'(s_ready1 & s_ready2), 1);
        end
        $display("step we=%0d din=%0d dout1=%0d dout2=%0d pos1=%0d pos2=%0d",
                 we, din, s_dout1, s_dout2, s_pos1, s_pos2);
    endtask

    task automatic bacc(input bit we, input int addr, input bit [7:0] din,
                        output bit [7:0] r1, output bit [7:0] r2);
        int lat;
        bit got;
        b_req = 1'b1; b_we = we; b_addr = AW'(addr); b_din = din;
        lat = 0; got = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            lat++;
            if (b_ack1) begin
                got = 1'b1;
                break;
            end
        end
        b_req = 1'b0;
        chk("b_ack_latency", got ? 32'(lat) : 32'd99, 2);
        chk("b_ack2", 32'(b_ack2), 1);
        if (we) begin
            mem_m[0][addr] = din;
            mem_m[1][addr] = din;
        end
        chk("b_dout1", 32'(b_dout1), int'(mem_m[0][addr]));
        chk("b_dout2", 32'(b_dout2), int'(mem_m[1][addr]));
        r1 = b_dout1;
        r2 = b_dout2;
        $display("byte we=%0d addr=%0d din=%02h dout1=%02h dout2=%02h", we, addr, din, b_dout1, b_dout2);
    endtask

    task automatic seek(input int v);
        s_seek = 1'b1; s_seek_pos = (AW+3)'(v);
        @(posedge clk); #1;
        s_seek = 1'b0;
        mseek(v);
        chk("seek_pos1", 32'(s_pos1), pos_m[0]);
        chk("seek_pos2", 32'(s_pos2), pos_m[1]);
        $display("seek pos=%0d pos1=%0d pos2=%0d", v, s_pos1, s_pos2);
    endtask

    // Seek and a read step in the same cycle: the step uses the old pointer, seek wins the update.
    task automatic seek_step(input int v);
        int e1, e2;
        s_seek = 1'b1; s_seek_pos = (AW+3)'(v); s_advance = 1'b1; s_we = 1'b0;
        @(posedge clk); #1;
        s_seek = 1'b0; s_advance = 1'b0;
        e1 = mstep(0, 1'b0, 2'b00);
        e2 = mstep(1, 1'b0, 2'b00);
        mseek(v);
        chk("seekstep_pos1", 32'(s_pos1), pos_m[0]);
        chk("seekstep_pos2", 32'(s_pos2), pos_m[1]);
        @(posedge clk); #1;
        chk("seekstep_dout1", 32'(s_dout1), e1);
        chk("seekstep_dout2", 32'(s_dout2), e2);
        $display("seekstep pos=%0d dout1=%0d dout2=%0d", v, s_dout1, s_dout2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit [7:0] r1, r2;
        int e1, e2;
        logic [15:0] pat;

        pat = 16'hA53C;
        for (int i = 0; i < 16; i++) begin
            tbl[i].exp1 = {1'b0, pat[15 - i]};
            tbl[i].exp2 = {pat[15 - 2 * (i % 8)], pat[14 - 2 * (i % 8)]};
        end

        reset = 1'b1; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
        s_len = '0; s_seek = 1'b0; s_seek_pos = '0; s_advance = 1'b0; s_we = 1'b0; s_din = '0;
`ifdef IECDRV_BITSTREAM_DIRTY_EN
        dirty_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_pos1", 32'(s_pos1), 0);
        chk("rst_s_pos2", 32'(s_pos2), 0);
        chk("rst_s_valid", 32'(s_valid1 | s_valid2), 0);
        chk("rst_s_dout", 32'({s_dout1, s_dout2}), 0);
        chk("rst_b_dout", 32'({b_dout1, b_dout2}), 0);
        chk("rst_b_ack", 32'(b_ack1 | b_ack2), 0);
        chk("rst_s_ready", 32'(s_ready1 & s_ready2), 1);
`ifdef IECDRV_BITSTREAM_DIRTY_EN
        chk("rst_dirty", 32'(dirty1 | dirty2), 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;
        len_m = 0;
        pos_m[0] = 0; pos_m[1] = 0;

        for (int a = 0; a < 64; a++) bacc(1'b1, a, 8'($urandom_range(0, 255)), r1, r2);

        // Two-byte track, MSB-first bit order and wrap after 16 bits.
        s_len = AW'(2); len_m = 2;
        seek(0);
        bacc(1'b1, 0, 8'hA5, r1, r2);
        bacc(1'b1, 1, 8'h3C, r1, r2);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 2'b00, e1, e2);
            chk("tbl_dout1", 32'(s_dout1), int'(tbl[i].exp1));
            chk("tbl_dout2", 32'(s_dout2), int'(tbl[i].exp2));
        end
        chk("wrap_pos1", 32'(s_pos1), 0);
        chk("wrap_pos2", 32'(s_pos2), 0);

        // Sub-byte read-modify-write stores.
        bacc(1'b1, 0, 8'h00, r1, r2);
        seek(0);
        step(1'b1, 2'b11, e1, e2);
        step(1'b1, 2'b00, e1, e2);
        bacc(1'b0, 0, 8'h00, r1, r2);
        chk("rmw_byte1", 32'(r1), 8'h80);
        chk("rmw_byte2", 32'(r2), 8'hC0);

        // Step and byte request together: step first, byte served afterwards.
        s_len = AW'(8); len_m = 8;
        s_advance = 1'b1; s_we = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = AW'(5);
        @(posedge clk); #1;
        s_advance = 1'b0;
        e1 = mstep(0, 1'b0, 2'b00);
        e2 = mstep(1, 1'b0, 2'b00);
        chk("arb_ack_n1", 32'(b_ack1), 0);
        @(posedge clk); #1;
        chk("arb_s_valid", 32'(s_valid1 & s_valid2), 1);
        chk("arb_s_dout1", 32'(s_dout1), e1);
        chk("arb_s_dout2", 32'(s_dout2), e2);
        chk("arb_ack_n2", 32'(b_ack1), 0);
        @(posedge clk); #1;
        chk("arb_ack_n3", 32'(b_ack1), 0);
        @(posedge clk); #1;
        chk("arb_ack_n4", 32'(b_ack1 & b_ack2), 1);
        chk("arb_b_dout1", 32'(b_dout1), int'(mem_m[0][5]));
        chk("arb_b_dout2", 32'(b_dout2), int'(mem_m[1][5]));
        b_req = 1'b0;
        $display("arb step+byte dout1=%0d b_dout1=%02h", s_dout1, b_dout1);

        // Seek during an in-flight read keeps the latched pointer.
        seek(3);
        s_advance = 1'b1; s_we = 1'b0;
        @(posedge clk); #1;
        s_advance = 1'b0;
        e1 = mstep(0, 1'b0, 2'b00);
        e2 = mstep(1, 1'b0, 2'b00);
        s_seek = 1'b1; s_seek_pos = (AW+3)'(9);
        @(posedge clk); #1;
        s_seek = 1'b0;
        chk("inflight_dout1", 32'(s_dout1), e1);
        chk("inflight_dout2", 32'(s_dout2), e2);
        chk("inflight_pos1", 32'(s_pos1), 9);
        chk("inflight_pos2", 32'(s_pos2), 8);
        mseek(9);
        $display("inflight seek dout1=%0d dout2=%0d pos1=%0d pos2=%0d", s_dout1, s_dout2, s_pos1, s_pos2);
        step(1'b0, 2'b00, e1, e2);

        // Reset while the merge write is pending: RAM must be untouched.
        bacc(1'b1, 0, 8'h00, r1, r2);
        seek(0);
        s_advance = 1'b1; s_we = 1'b1; s_din = 2'b11;
        @(posedge clk); #1;
        s_advance = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        chk("rstmid_ready", 32'(s_ready1 & s_ready2), 1);
        chk("rstmid_pos", 32'({s_pos1, s_pos2}), 0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        pos_m[0] = 0; pos_m[1] = 0;
        bacc(1'b0, 0, 8'h00, r1, r2);
        chk("rstmid_byte", 32'({r1, r2}), 0);

`ifdef IECDRV_BITSTREAM_DIRTY_EN
        dirty_clr = 1'b1;
        @(posedge clk); #1;
        dirty_clr = 1'b0;
        chk("dirty_clr", 32'(dirty1 | dirty2), 0);
        step(1'b1, 2'b01, e1, e2);
        chk("dirty_after_step", 32'(dirty1 & dirty2), 1);
        dirty_clr = 1'b1;
        @(posedge clk); #1;
        dirty_clr = 1'b0;
        chk("dirty_clr2", 32'(dirty1 | dirty2), 0);
        b_req = 1'b1; b_we = 1'b1; b_addr = AW'(7); b_din = 8'h5A; dirty_clr = 1'b1;
        @(posedge clk); #1;
        dirty_clr = 1'b0;
        chk("dirty_set_wins", 32'(dirty1 & dirty2), 1);
        @(posedge clk); #1;
        chk("dirty_bw_ack", 32'(b_ack1), 1);
        b_req = 1'b0;
        mem_m[0][7] = 8'h5A; mem_m[1][7] = 8'h5A;
        $display("dirty set/clr same cycle dirty1=%0d dirty2=%0d", dirty1, dirty2);
`endif

        // Randomized mix against the bit-array model.
        for (int it = 0; it < 300; it++) begin
            int op;
            op = int'($urandom_range(0, 10));
            if (op <= 3) step(1'b0, 2'b00, e1, e2);
            else if (op <= 5) step(1'b1, 2'($urandom_range(0, 3)), e1, e2);
            else if (op == 6) bacc(1'b0, int'($urandom_range(0, 63)), 8'h00, r1, r2);
            else if (op == 7) bacc(1'b1, int'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), r1, r2);
            else if (op == 8) seek(int'($urandom_range(0, 511)));
            else if (op == 9) seek_step(int'($urandom_range(0, 511)));
            else begin
                len_m = int'($urandom_range(0, 8));
                s_len = AW'(len_m);
                @(posedge clk); #1;
                $display("len set %0d", len_m);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iecdrv_bitstream_mem.md
# iecdrv_bitstream_mem

Track buffer for the IEC drive model: one byte-wide RAM with two access paths. The bit-stream path is a self-advancing, wrap-around pointer that reads or writes NARROW bits per step. The byte path serves the drive CPU / image loader. It supersedes the fixed 1-bit dual-width memory, adding:
- configurable narrow width
- a hardware track-length wrap
- read-modify-write sub-byte stores
- a single-clock handshake arbiter in place of true dual-port RAM

## Interface
Parameters:
- ADDRWIDTH, 13 — byte address width; buffer holds 2^ADDRWIDTH bytes.
- NARROW, 1 — bits per stream step; legal values 1, 2, 4, 8.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  — sole clock, all logic on rising edge.
- reset  in  1  — asynchronous, active-high.
- b_req  in  1  — byte request, level, held until b_ack.
- b_we  in  1  — 1 = write, 0 = read; sampled with b_req.
- b_addr  in  ADDRWIDTH  — byte address.
- b_din  in  8  — byte write data.
- b_dout  out  8  — byte read data, valid with b_ack.
- b_ack  out  1  — one-cycle completion pulse.
- s_len  in  ADDRWIDTH  — track length in bytes; 0 means 2^ADDRWIDTH.
- s_seek  in  1  — load the pointer from s_seek_pos.
- s_seek_pos  in  ADDRWIDTH+3  — bit position to load.
- s_advance  in  1  — stream step request; accepted only when s_ready is high.
- s_we  in  1  — step is a write; sampled with s_advance.
- s_din  in  NARROW  — stream write data.
- s_ready  out  1  — arbiter idle; combinational from state.
- s_dout  out  NARROW  — stream read data.
- s_valid  out  1  — one-cycle pulse qualifying s_dout.
- s_pos  out  ADDRWIDTH+3  — current bit pointer.
- dirty  out  1  — only with IECDRV_BITSTREAM_DIRTY_EN.
- dirty_clr  in  1  — only with IECDRV_BITSTREAM_DIRTY_EN.

## Operation
- States: IDLE, SREAD, SMERGE, BACC. s_ready = (state == IDLE).
- In IDLE, s_advance wins over b_req; a byte request waits while steps keep arriving. Stream has a real-time deadline.
- Accepted step:
  - Latch op pointer P = s_pos, byte address P[ADDRWIDTH+2:3], offset o = P[2:0].
  - Issue RAM read; go to SREAD.
  - Advance s_pos to P+NARROW, or to 0 if P+NARROW ≥ 8·s_len (effective length).
- SREAD, read step: s_dout = byte[7-o -: NARROW] (MSB-first disk order); pulse s_valid; go to IDLE.
- SREAD, write step: go to SMERGE. SMERGE writes the byte with field [7-o -: NARROW] replaced by s_din, other bits unchanged; go to IDLE. No s_valid on writes.
- Accepted byte request: go to BACC. Perform the RAM read or write; register b_dout (write returns b_din); pulse b_ack; go to IDLE.
- s_seek acts in any state and has priority over the same-cycle advance increment. An in-flight step keeps its latched P.
- s_seek_pos must be NARROW-aligned. Misaligned low bits are cleared.
- Out-of-range pointer (s_len lowered below s_pos) wraps to 0 on the next step.
- Reset mid-operation:
  - State to IDLE; the pending op is dropped.
  - RAM contents are not cleared.
  - The byte master must re-issue its request.

## Timing
- Reset values: s_pos 0, s_dout 0, s_valid 0, b_dout 0, b_ack 0, dirty 0, state IDLE (so s_ready 1).
- Stream read accepted at cycle N: s_valid/s_dout at N+2; s_ready high at N+2.
- Stream write accepted at N: RAM updated at the N+2 edge; s_ready high at N+3.
- s_pos updates at the N+1 edge.
- Byte access accepted at N: b_ack at N+2; s_ready high at N+2.
- Maximum stream rate: one read per 2 cycles, one write per 3 cycles.

## Configuration
- IECDRV_BITSTREAM_DIRTY_EN defined:
  - dirty sets on any SMERGE write or byte write.
  - dirty_clr clears it.
  - If both occur in the same cycle, set wins.
- Not defined: the dirty and dirty_clr ports do not exist.

## Structure
- Package iecdrv_pkg:
  - state enum
  - legal-NARROW check function
  - MSB-first field extract/merge functions
- Sub-module iecdrv_spram: single-port synchronous byte RAM, read-first, one-cycle read latency. The arbiter owns the only port.

## Test plan
- NARROW=1, s_len=2: byte-write 0xA5 to addr 0, then 16 read steps → s_dout 1,0,1,0,0,1,0,1, then addr-1 bits; s_pos wraps to 0 after step 16.
- NARROW=2: write steps 11,00 at bits 0/2 over byte 0x00 → byte read returns 0xC0.
- s_advance and b_req asserted together → s_valid at N+2, b_ack at N+4.
- s_seek to 9 during SREAD of P=3 → s_dout is from bit 3; next step uses bit 8 (aligned) with NARROW=2.
- Reset in SMERGE → byte unchanged on readback; s_ready 1; s_pos 0.
- DIRTY_EN: write step sets dirty; dirty_clr and a write in the same cycle → dirty stays 1.
